// File: rtl/cofre_controle.sv
// Purpose: sequential front end of the safe; captures password/attempt, tracks open state, enforces lockout.
// Latency: button edge -> register/state update at the closing clock edge; match result sampled in the single AVALIA cycle.
// Backpressure: none; button events that the current state does not consume are dropped, never queued.
module cofre_controle #(
    parameter int MAX_TENTATIVAS  = 3,
    parameter int BLOQUEIO_CICLOS = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] entrada,
    input  logic       btn_gravar,
    input  logic       btn_confirmar,
    input  logic       acerto,
    output logic [3:0] senha,
    output logic [3:0] tentativa,
    output logic       valida,
    output logic       cofre_aberto,
    output logic       bloqueado,
    output logic [3:0] erros,
    output logic       programado
);

    localparam int TW = $clog2(BLOQUEIO_CICLOS + 1);

    localparam logic [2:0] S_PROGRAMAR = 3'd0;
    localparam logic [2:0] S_ESPERA    = 3'd1;
    localparam logic [2:0] S_AVALIA    = 3'd2;
    localparam logic [2:0] S_ABERTO    = 3'd3;
    localparam logic [2:0] S_BLOQUEADO = 3'd4;

    localparam logic [3:0]    MAX_V   = 4'(MAX_TENTATIVAS);
    localparam logic [TW-1:0] BLOQ_V  = TW'(BLOQUEIO_CICLOS);
    localparam logic [TW-1:0] TIMER_1 = TW'(1);

    logic [2:0]    estado_q,     estado_d;
    logic [3:0]    senha_q,      senha_d;
    logic [3:0]    tentativa_q,  tentativa_d;
    logic [3:0]    erros_q,      erros_d;
    logic          programado_q, programado_d;
    logic [TW-1:0] timer_q,      timer_d;
    logic          gravar_ant_q, gravar_ant_d;
    logic          confirmar_ant_q, confirmar_ant_d;

    logic          ev_gravar;
    logic          ev_confirmar;
    logic [3:0]    erros_inc;

    // Rising-edge detect against the previous-cycle button sample.
    always_comb begin
        gravar_ant_d    = btn_gravar;
        confirmar_ant_d = btn_confirmar;
        ev_gravar       = btn_gravar    & ~gravar_ant_q;
        ev_confirmar    = btn_confirmar & ~confirmar_ant_q;
        erros_inc       = erros_q + 4'd1;
    end

    // Next-state and datapath updates; unconsumed events simply fall through.
    always_comb begin
        estado_d     = estado_q;
        senha_d      = senha_q;
        tentativa_d  = tentativa_q;
        erros_d      = erros_q;
        programado_d = programado_q;
        timer_d      = timer_q;

        case (estado_q)
            S_PROGRAMAR: begin
                if (ev_gravar) begin
                    senha_d      = entrada;
                    programado_d = 1'b1;
                    estado_d     = S_ESPERA;
                end
            end
            S_ESPERA: begin
                if (ev_confirmar) begin
                    tentativa_d = entrada;
                    estado_d    = S_AVALIA;
                end
            end
            S_AVALIA: begin
                if (acerto) begin
                    erros_d  = 4'd0;
                    estado_d = S_ABERTO;
                end else if (erros_inc >= MAX_V) begin
                    erros_d  = erros_inc;
                    timer_d  = BLOQ_V;
                    estado_d = S_BLOQUEADO;
                end else begin
                    erros_d  = erros_inc;
                    estado_d = S_ESPERA;
                end
            end
            S_ABERTO: begin
                // A simultaneous press favours re-programming; the close request is dropped.
                if (ev_gravar) begin
                    senha_d = entrada;
                end else if (ev_confirmar) begin
                    estado_d = S_ESPERA;
                end
            end
            S_BLOQUEADO: begin
                // Timer at 1 (or a stray 0) ends the lockout so it lasts exactly BLOQUEIO_CICLOS cycles.
                if (timer_q <= TIMER_1) begin
                    erros_d  = 4'd0;
                    timer_d  = '0;
                    estado_d = S_ESPERA;
                end else begin
                    timer_d = timer_q - TIMER_1;
                end
            end
            default: begin
                estado_d = S_PROGRAMAR;
            end
        endcase
    end

    // State registers; edge registers reset high so a held button yields no event after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q        <= S_PROGRAMAR;
            senha_q         <= 4'd0;
            tentativa_q     <= 4'd0;
            erros_q         <= 4'd0;
            programado_q    <= 1'b0;
            timer_q         <= '0;
            gravar_ant_q    <= 1'b1;
            confirmar_ant_q <= 1'b1;
        end else begin
            estado_q        <= estado_d;
            senha_q         <= senha_d;
            tentativa_q     <= tentativa_d;
            erros_q         <= erros_d;
            programado_q    <= programado_d;
            timer_q         <= timer_d;
            gravar_ant_q    <= gravar_ant_d;
            confirmar_ant_q <= confirmar_ant_d;
        end
    end

    assign senha        = senha_q;
    assign tentativa    = tentativa_q;
    assign erros        = erros_q;
    assign programado   = programado_q;
    assign valida       = (estado_q == S_AVALIA);
    assign cofre_aberto = (estado_q == S_ABERTO);
    assign bloqueado    = (estado_q == S_BLOQUEADO);

endmodule

// File: tb/tb_cofre_controle.sv
// Scoreboard bench for cofre_controle with short lockout (MAX_TENTATIVAS=3, BLOQUEIO_CICLOS=10).
// Each submitted attempt pushes its expected evaluation; a negedge monitor checks it when valida rises.
// Direct checks cover reset, button-edge handling, lockout length and reset during lockout.
module tb_cofre_controle;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] entrada;
    logic       btn_gravar;
    logic       btn_confirmar;
    logic       acerto;
    logic [3:0] senha;
    logic [3:0] tentativa;
    logic       valida;
    logic       cofre_aberto;
    logic       bloqueado;
    logic [3:0] erros;
    logic       programado;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] tent;
        logic [3:0] senha;
        logic [3:0] erros;
        logic       aberto;
        logic       bloq;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    logic pend = 1'b0;

    always #5 clk = ~clk;

    // Emulation of the external combinational password checker.
    assign acerto = (tentativa == senha);

    cofre_controle #(
        .MAX_TENTATIVAS (3),
        .BLOQUEIO_CICLOS(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entrada      (entrada),
        .btn_gravar   (btn_gravar),
        .btn_confirmar(btn_confirmar),
        .acerto       (acerto),
        .senha        (senha),
        .tentativa    (tentativa),
        .valida       (valida),
        .cofre_aberto (cofre_aberto),
        .bloqueado    (bloqueado),
        .erros        (erros),
        .programado   (programado)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every valida cycle and checks the outcome one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            chk("sb_erros",  32'(erros),        32'(cur.erros));
            chk("sb_aberto", 32'(cofre_aberto), 32'(cur.aberto));
            chk("sb_bloq",   32'(bloqueado),    32'(cur.bloq));
            pend = 1'b0;
        end
        if (valida === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valida", 32'(valida), 32'(0));
            end else begin
                cur = sb_q.pop_front();
                chk("sb_tentativa", 32'(tentativa), 32'(cur.tent));
                chk("sb_senha",     32'(senha),     32'(cur.senha));
                pend = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_gravar(input logic [3:0] v);
        @(posedge clk); #1;
        entrada = v; btn_gravar = 1'b1;
        @(posedge clk); #1;
        btn_gravar = 1'b0;
    endtask

    task automatic pulse_confirmar(input logic [3:0] v);
        @(posedge clk); #1;
        entrada = v; btn_confirmar = 1'b1;
        @(posedge clk); #1;
        btn_confirmar = 1'b0;
    endtask

    task automatic pulse_ambos(input logic [3:0] v);
        @(posedge clk); #1;
        entrada = v; btn_gravar = 1'b1; btn_confirmar = 1'b1;
        @(posedge clk); #1;
        btn_gravar = 1'b0; btn_confirmar = 1'b0;
    endtask

    // Submit an attempt; returns one cycle after the AVALIA cycle ends.
    task automatic tentar(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                          input logic a, input logic b);
        exp_t x;
        x.tent = v; x.senha = s; x.erros = e; x.aberto = a; x.bloq = b;
        sb_q.push_back(x);
        pulse_confirmar(v);
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset = 1'b1; entrada = 4'h0; btn_gravar = 1'b1; btn_confirmar = 1'b0;
        step(3);
        chk("rst_senha",      32'(senha),        32'(0));
        chk("rst_tentativa",  32'(tentativa),    32'(0));
        chk("rst_valida",     32'(valida),       32'(0));
        chk("rst_aberto",     32'(cofre_aberto), 32'(0));
        chk("rst_bloq",       32'(bloqueado),    32'(0));
        chk("rst_erros",      32'(erros),        32'(0));
        chk("rst_programado", 32'(programado),   32'(0));

        // Gravar held high through reset release must not count as an event.
        entrada = 4'h6;
        reset = 1'b0;
        step(3);
        chk("held_btn_programado", 32'(programado), 32'(0));
        chk("held_btn_senha",      32'(senha),      32'(0));
        btn_gravar = 1'b0;
        step(1);

        // Confirmar is ignored while unprogrammed.
        pulse_confirmar(4'h5);
        step(1);
        chk("prog_conf_ignored", 32'(tentativa), 32'(0));

        pulse_gravar(4'h9);
        chk("prog_senha",      32'(senha),      32'(9));
        chk("prog_programado", 32'(programado), 32'(1));

        // Correct attempt opens; re-program to 3, close.
        tentar(4'h9, 4'h9, 4'd0, 1'b1, 1'b0);
        pulse_gravar(4'h3);
        chk("aberto_gravar_senha", 32'(senha), 32'(3));
        chk("aberto_still_open",   32'(cofre_aberto), 32'(1));
        pulse_confirmar(4'hE);
        chk("close_aberto",    32'(cofre_aberto), 32'(0));
        chk("close_tentativa", 32'(tentativa),    32'(9));

        // Open with 3, re-program back to 9, close.
        tentar(4'h3, 4'h3, 4'd0, 1'b1, 1'b0);
        pulse_gravar(4'h9);
        pulse_confirmar(4'h0);

        // Gravar in ESPERA leaves the password alone.
        pulse_gravar(4'h2);
        chk("espera_gravar_ignored", 32'(senha), 32'(9));

        // Three wrong attempts -> lockout of exactly 10 cycles, buttons ignored meanwhile.
        tentar(4'h1, 4'h9, 4'd1, 1'b0, 1'b0);
        tentar(4'h2, 4'h9, 4'd2, 1'b0, 1'b0);
        tentar(4'h5, 4'h9, 4'd3, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bloqueado !== 1'b1) break;
            cnt++;
            if (cnt == 2) begin entrada = 4'h9; btn_gravar = 1'b1; btn_confirmar = 1'b1; end
            if (cnt == 4) begin btn_gravar = 1'b0; btn_confirmar = 1'b0; end
            if (cnt == 6) begin entrada = 4'h4; btn_confirmar = 1'b1; end
            if (cnt == 7) begin btn_confirmar = 1'b0; end
            step(1);
        end
        chk("lock_cycles",    32'(cnt),       32'(10));
        chk("lock_erros_clr", 32'(erros),     32'(0));
        chk("lock_senha",     32'(senha),     32'(9));
        chk("lock_tentativa", 32'(tentativa), 32'(5));
        chk("lock_valida",    32'(valida),    32'(0));

        // Back in ESPERA: two wrong then correct clears the count.
        tentar(4'h1, 4'h9, 4'd1, 1'b0, 1'b0);
        tentar(4'h2, 4'h9, 4'd2, 1'b0, 1'b0);
        tentar(4'h9, 4'h9, 4'd0, 1'b1, 1'b0);
        pulse_confirmar(4'h0);
        tentar(4'h4, 4'h9, 4'd1, 1'b0, 1'b0);

        // Simultaneous press in ABERTO: gravar wins.
        tentar(4'h9, 4'h9, 4'd0, 1'b1, 1'b0);
        pulse_ambos(4'h7);
        chk("both_senha",  32'(senha),        32'(7));
        chk("both_aberto", 32'(cofre_aberto), 32'(1));
        pulse_confirmar(4'h0);
        chk("both_closed", 32'(cofre_aberto), 32'(0));
        pulse_gravar(4'h2);
        chk("espera_gravar_ignored2", 32'(senha), 32'(7));

        // Reset in the 4th lockout cycle.
        tentar(4'h1, 4'h7, 4'd1, 1'b0, 1'b0);
        tentar(4'h2, 4'h7, 4'd2, 1'b0, 1'b0);
        tentar(4'h3, 4'h7, 4'd3, 1'b0, 1'b1);
        step(3);
        chk("lock_cycle4_bloq", 32'(bloqueado), 32'(1));
        reset = 1'b1;
        step(1);
        chk("midlock_rst_bloq",       32'(bloqueado),  32'(0));
        chk("midlock_rst_erros",      32'(erros),      32'(0));
        chk("midlock_rst_programado", 32'(programado), 32'(0));
        chk("midlock_rst_senha",      32'(senha),      32'(0));
        chk("midlock_rst_tentativa",  32'(tentativa),  32'(0));
        reset = 1'b0;
        step(1);
        pulse_gravar(4'hA);
        chk("post_rst_prog_senha", 32'(senha),      32'(10));
        chk("post_rst_programado", 32'(programado), 32'(1));

        step(3);
        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
